// File: rtl/detector_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : detector_sequencer_pkg
// Brief   : State encoding and default sizing for the detector test sequencer.
// Rev     : 1.0
// ============================================================================
package detector_sequencer_pkg;

    localparam int LEN_DEFAULT   = 16;
    localparam int CNT_W_DEFAULT = 5;
    localparam int IDX_W_DEFAULT = 4;
    localparam int STATE_W       = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'b000,
        ST_CLEAR  = 3'b001,
        ST_STREAM = 3'b010,
        ST_DRAIN  = 3'b011,
        ST_DONE   = 3'b100
    } state_e;

endpackage
`default_nettype wire

// File: rtl/detector_sequencer_dff.sv
`default_nettype none
// ============================================================================
// Module  : detector_sequencer_dff
// Brief   : Single-bit D flip-flop with synchronous active-high reset value.
// Rev     : 1.0
// ============================================================================
module detector_sequencer_dff #(
    parameter logic DEFAULT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    always_ff @(posedge clk) begin
        if (reset) q_o <= DEFAULT;
        else       q_o <= d_i;
    end

endmodule
`default_nettype wire

// File: rtl/detector_sequencer_piso.sv
`default_nettype none
// ============================================================================
// Module  : detector_sequencer_piso
// Brief   : LEN-bit parallel-load, shift-right register exposing bit 0.
// Rev     : 1.0
// ============================================================================
module detector_sequencer_piso #(
    parameter int LEN = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_i,
    input  logic           shift_i,
    input  logic [LEN-1:0] data_i,
    output logic           bit0_o
);

    logic [LEN-1:0] shift_q;

    always_ff @(posedge clk) begin
        if (reset)        shift_q <= '0;
        else if (load_i)  shift_q <= data_i;
        else if (shift_i) shift_q <= {1'b0, shift_q[LEN-1:1]};
    end

    assign bit0_o = shift_q[0];

endmodule
`default_nettype wire

// File: rtl/detector_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : detector_sequencer
// Brief   : Streams a captured pattern into a sequence detector and tallies z.
// Rev     : 1.0
// ============================================================================
module detector_sequencer
    import detector_sequencer_pkg::*;
#(
    parameter int LEN   = LEN_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int IDX_W = IDX_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN-1:0]   pattern,
    output logic             busy,
    output logic             done,
    output logic             det_reset,
    output logic             w_out,
    input  logic             z_in,
    output logic [CNT_W-1:0] det_count,
    output logic [IDX_W-1:0] first_hit,
    output logic             hit_valid
);

    logic [STATE_W-1:0] state_bits_q;
    logic [STATE_W-1:0] state_bits_d;
    state_e             state_q;
    state_e             state_d;

    logic [IDX_W-1:0]   bit_cnt_q;
    logic [IDX_W-1:0]   bit_cnt_d;
    logic [CNT_W-1:0]   count_q;
    logic [IDX_W-1:0]   first_q;
    logic               hit_q;

    logic               load;
    logic               shift;
    logic               shift_bit;
    logic               smp_valid;
    logic [IDX_W-1:0]   smp_idx;

    generate
        for (genvar i = 0; i < STATE_W; i++) begin : g_state_bit
            detector_sequencer_dff #(.DEFAULT(1'b0)) u_dff (
                .clk   (clk),
                .reset (reset),
                .d_i   (state_bits_d[i]),
                .q_o   (state_bits_q[i])
            );
        end
    endgenerate

    assign state_q      = state_e'(state_bits_q);
    assign state_bits_d = state_d;

    detector_sequencer_piso #(.LEN(LEN)) u_piso (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (pattern),
        .bit0_o  (shift_bit)
    );

    // z lags w by one cycle: STREAM cycle k reports bit k-1, DRAIN reports the last bit.
    always_comb begin
        state_d   = ST_IDLE;
        bit_cnt_d = bit_cnt_q;
        load      = 1'b0;
        shift     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        det_reset = 1'b0;
        w_out     = 1'b0;
        smp_valid = 1'b0;
        smp_idx   = '0;
        case (state_q)
            ST_IDLE: begin
                load    = start;
                state_d = start ? ST_CLEAR : ST_IDLE;
            end
            ST_CLEAR: begin
                busy      = 1'b1;
                det_reset = 1'b1;
                bit_cnt_d = '0;
                state_d   = ST_STREAM;
            end
            ST_STREAM: begin
                busy      = 1'b1;
                w_out     = shift_bit;
                shift     = 1'b1;
                smp_valid = (bit_cnt_q != '0);
                smp_idx   = bit_cnt_q - 1'b1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                state_d   = (bit_cnt_q == IDX_W'(LEN - 1)) ? ST_DRAIN : ST_STREAM;
            end
            ST_DRAIN: begin
                busy      = 1'b1;
                smp_valid = 1'b1;
                smp_idx   = IDX_W'(LEN - 1);
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q <= '0;
            count_q   <= '0;
            first_q   <= '0;
            hit_q     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            if (load) begin
                count_q <= '0;
                first_q <= '0;
                hit_q   <= 1'b0;
            end else if (smp_valid && z_in) begin
                if (count_q != '1) count_q <= count_q + 1'b1;
                if (!hit_q) begin
                    hit_q   <= 1'b1;
                    first_q <= smp_idx;
                end
            end
        end
    end

    assign det_count = count_q;
    assign first_hit = first_q;
    assign hit_valid = hit_q;

endmodule
`default_nettype wire

// File: tb/tb_detector_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_detector_sequencer
// Brief   : Directed scoreboard bench for detector_sequencer (CNT_W=5 and 3).
// Rev     : 1.0
// ============================================================================
module tb_detector_sequencer;

    localparam int LEN = 16;

    logic clk = 1'b0;
    logic reset, start, z_in;
    logic [LEN-1:0] pattern;

    logic       busy, done, det_reset, w_out, hit_valid;
    logic [4:0] det_count;
    logic [3:0] first_hit;
    logic       busy_s, done_s, det_reset_s, w_out_s, hit_valid_s;
    logic [2:0] det_count_s;
    logic [3:0] first_hit_s;

    typedef struct {
        logic [4:0] cnt;
        logic [2:0] cnt_s;
        logic [3:0] first;
        logic       hit;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    detector_sequencer #(.LEN(LEN), .CNT_W(5), .IDX_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern),
        .busy(busy), .done(done), .det_reset(det_reset), .w_out(w_out),
        .z_in(z_in), .det_count(det_count), .first_hit(first_hit),
        .hit_valid(hit_valid)
    );

    detector_sequencer #(.LEN(LEN), .CNT_W(3), .IDX_W(4)) dut_s (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern),
        .busy(busy_s), .done(done_s), .det_reset(det_reset_s), .w_out(w_out_s),
        .z_in(z_in), .det_count(det_count_s), .first_hit(first_hit_s),
        .hit_valid(hit_valid_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // zm bit j = z_in during STREAM cycle j (j<16), bit 16 = z_in during DRAIN.
    function automatic exp_t model(input logic [16:0] zm);
        exp_t e;
        e.cnt = '0; e.cnt_s = '0; e.first = '0; e.hit = 1'b0;
        for (int j = 1; j <= LEN; j++) begin
            if (zm[j]) begin
                if (e.cnt != 5'd31) e.cnt = e.cnt + 5'd1;
                if (e.cnt_s != 3'd7) e.cnt_s = e.cnt_s + 3'd1;
                if (!e.hit) begin
                    e.hit   = 1'b1;
                    e.first = 4'(j - 1);
                end
            end
        end
        return e;
    endfunction

    task automatic run(input logic [LEN-1:0] pat, input logic [16:0] zm, input bit noisy);
        exp_t e;
        logic [LEN-1:0] cap;
        cap     = pat;
        pattern = pat;
        start   = 1'b1;
        z_in    = 1'b0;
        sb.push_back(model(zm));
        tick();
        chk("clear_det_reset", det_reset, 1);
        chk("clear_busy", busy, 1);
        chk("clear_w_out", w_out, 0);
        start = noisy;
        if (noisy) pattern = ~pat;
        for (int k = 0; k < LEN; k++) begin
            tick();
            chk($sformatf("stream_w_out[%0d]", k), w_out, cap[k]);
            chk("stream_busy", busy, 1);
            z_in = zm[k];
            if (noisy) pattern = 16'($urandom);
        end
        tick();
        chk("drain_w_out", w_out, 0);
        chk("drain_busy", busy, 1);
        z_in = zm[16];
        tick();
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("det_count", det_count, e.cnt);
            chk("first_hit", first_hit, e.first);
            chk("hit_valid", hit_valid, e.hit);
            chk("det_count_sat", det_count_s, e.cnt_s);
            chk("first_hit_sat", first_hit_s, e.first);
        end
        z_in  = 1'b0;
        start = noisy;
        tick();
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_det_reset", det_reset, 0);
        start = 1'b0;
        tick();
        chk("idle_hold_busy", busy, 0);
        chk("idle_hold_done", done, 0);
        chk("idle_hold_count", det_count, e.cnt);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b1;
        z_in    = 1'b0;
        pattern = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_det_reset", det_reset, 0);
            chk("rst_w_out", w_out, 0);
            chk("rst_count", det_count, 0);
            chk("rst_first", first_hit, 0);
            chk("rst_hit", hit_valid, 0);
        end
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_det_reset", det_reset, 0);

        run(16'h00F0, 17'h000C0, 1'b0);   // hits attributed to bits 5 and 6
        run(16'hA5A5, 17'h10000, 1'b0);   // DRAIN-only hit -> bit 15
        run(16'h3C3C, 17'h00001, 1'b0);   // cycle-0 z ignored
        run(16'h1357, 17'h1FFFF, 1'b0);   // saturation on the 3-bit counter

        // reset during STREAM cycle 7 discards the run
        pattern = 16'hA5C3;
        start   = 1'b1;
        tick();
        start = 1'b0;
        z_in  = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        reset = 1'b1;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_w_out", w_out, 0);
        chk("midrst_count", det_count, 0);
        chk("midrst_hit", hit_valid, 0);
        chk("midrst_done", done, 0);
        reset = 1'b0;
        z_in  = 1'b0;
        tick();
        chk("midrst_no_done", done, 0);
        chk("midrst_idle", busy, 0);

        run(16'h1234, 17'($urandom), 1'b0);
        run(16'h8421, 17'h0A482, 1'b1);   // start/pattern noise while busy and in DONE

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
